// File: rtl/rominit_seq.sv
// Routes the single download port onto one ROMINIT region, size-checks it and gates core reset.
// Latency: ROMINIT write 1 cycle after DL_WR; no backpressure, every DL_WR is accepted or dropped.
module rominit_seq #(
  parameter int IDX_BOOT    = 0,
  parameter int IDX_CHR     = 1,
  parameter int IDX_APU     = 2,
  parameter int IDX_CART    = 3,
  parameter int BOOT_SIZE   = 4096,
  parameter int CHR_SIZE    = 1024,
  parameter int APU_SIZE    = 2048,
  parameter int CART_MAX    = 131072,
  parameter int HOLD_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        DL_ACTIVE,
  input  logic [7:0]  DL_INDEX,
  input  logic [7:0]  DL_DATA,
  input  logic        DL_WR,
  output logic        ROMINIT_SEL_BOOT,
  output logic        ROMINIT_SEL_CHR,
  output logic        ROMINIT_SEL_APU,
  output logic        ROMINIT_SEL_CART,
  output logic [24:0] ROMINIT_ADDR,
  output logic [7:0]  ROMINIT_DATA,
  output logic        ROMINIT_VALID,
  output logic [24:0] CART_SIZE,
  output logic        READY,
  output logic        SYS_RESB,
  output logic        ERR
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [7:0]    IDX_BOOT_B = 8'(IDX_BOOT);
  localparam logic [7:0]    IDX_CHR_B  = 8'(IDX_CHR);
  localparam logic [7:0]    IDX_APU_B  = 8'(IDX_APU);
  localparam logic [7:0]    IDX_CART_B = 8'(IDX_CART);
  localparam logic [24:0]   BOOT_LIM   = 25'(BOOT_SIZE);
  localparam logic [24:0]   CHR_LIM    = 25'(CHR_SIZE);
  localparam logic [24:0]   APU_LIM    = 25'(APU_SIZE);
  localparam logic [24:0]   CART_LIM   = 25'(CART_MAX);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SKIP,
    ST_CHECK
  } state_t;

  state_t        state_q, state_d;
  logic          dl_active_q, dl_active_d;
  // select bits: [0] boot, [1] chr, [2] apu, [3] cart
  logic [3:0]    sel_q, sel_d;
  logic [24:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic [24:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [24:0]   cart_size_q, cart_size_d;
  logic [2:0]    loaded_q, loaded_d;
  logic          ready_q, ready_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          sys_resb_q, sys_resb_d;
  logic          err_q, err_d;

  logic [3:0]    idx_sel;
  logic [24:0]   lim;
  logic          size_ok;

  always_comb begin
    idx_sel = 4'b0000;
    if (DL_INDEX == IDX_BOOT_B)      idx_sel = 4'b0001;
    else if (DL_INDEX == IDX_CHR_B)  idx_sel = 4'b0010;
    else if (DL_INDEX == IDX_APU_B)  idx_sel = 4'b0100;
    else if (DL_INDEX == IDX_CART_B) idx_sel = 4'b1000;

    lim = '0;
    if (sel_q[0])      lim = BOOT_LIM;
    else if (sel_q[1]) lim = CHR_LIM;
    else if (sel_q[2]) lim = APU_LIM;
    else if (sel_q[3]) lim = CART_LIM;
  end

  always_comb begin
    state_d     = state_q;
    dl_active_d = DL_ACTIVE;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    valid_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    cart_size_d = cart_size_q;
    loaded_d    = loaded_q;
    hold_d      = hold_q;
    err_d       = err_q;
    size_ok     = 1'b0;

    if ((state_q == ST_IDLE || state_q == ST_SKIP) && hold_q != '0)
      hold_d = hold_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (DL_ACTIVE && !dl_active_q) begin
          if (idx_sel != 4'b0000) begin
            state_d  = ST_LOAD;
            sel_d    = idx_sel;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            hold_d   = HOLD_INIT;
            loaded_d = loaded_q & ~idx_sel[2:0];
          end else begin
            state_d = ST_SKIP;
          end
        end
      end

      ST_LOAD: begin
        if (DL_WR) begin
          // counter stops at the limit, so extra bytes only mark overflow
          if (cnt_q < lim) begin
            valid_d = 1'b1;
            addr_d  = cnt_q;
            data_d  = DL_DATA;
            cnt_d   = cnt_q + 25'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (!DL_ACTIVE)
          state_d = ST_CHECK;
      end

      ST_SKIP: begin
        if (!DL_ACTIVE)
          state_d = ST_IDLE;
      end

      ST_CHECK: begin
        state_d = ST_IDLE;
        sel_d   = 4'b0000;
        if (sel_q[3]) begin
          if (cnt_q != '0 && cnt_q <= CART_LIM && !ovf_q)
            cart_size_d = cnt_q;
          else
            err_d = 1'b1;
        end else begin
          size_ok  = (cnt_q == lim) && !ovf_q;
          loaded_d = (loaded_q & ~sel_q[2:0]) | (size_ok ? sel_q[2:0] : 3'b000);
          if (!size_ok)
            err_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ready_d    = &loaded_d;
    sys_resb_d = ready_d && (hold_d == '0) && (state_d == ST_IDLE || state_d == ST_SKIP);
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= ST_IDLE;
      dl_active_q <= 1'b0;
      sel_q       <= 4'b0000;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cart_size_q <= '0;
      loaded_q    <= 3'b000;
      ready_q     <= 1'b0;
      hold_q      <= '0;
      sys_resb_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_active_q <= dl_active_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cart_size_q <= cart_size_d;
      loaded_q    <= loaded_d;
      ready_q     <= ready_d;
      hold_q      <= hold_d;
      sys_resb_q  <= sys_resb_d;
      err_q       <= err_d;
    end
  end

  assign ROMINIT_SEL_BOOT = sel_q[0];
  assign ROMINIT_SEL_CHR  = sel_q[1];
  assign ROMINIT_SEL_APU  = sel_q[2];
  assign ROMINIT_SEL_CART = sel_q[3];
  assign ROMINIT_ADDR     = addr_q;
  assign ROMINIT_DATA     = data_q;
  assign ROMINIT_VALID    = valid_q;
  assign CART_SIZE        = cart_size_q;
  assign READY            = ready_q;
  assign SYS_RESB         = sys_resb_q;
  assign ERR              = err_q;

  sel_onehot_a: assert property (@(posedge CLK) disable iff (RES) $onehot0(sel_q));

endmodule

// File: tb/tb_rominit_seq.sv
// Scoreboard bench for rominit_seq: every accepted byte is queued at drive time and matched at ROMINIT_VALID.
module tb_rominit_seq;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        DL_ACTIVE = 1'b0;
  logic [7:0]  DL_INDEX = 8'd0;
  logic [7:0]  DL_DATA = 8'd0;
  logic        DL_WR = 1'b0;
  logic        ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_APU, ROMINIT_SEL_CART;
  logic [24:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        ROMINIT_VALID;
  logic [24:0] CART_SIZE;
  logic        READY, SYS_RESB, ERR;

  always #5 CLK = ~CLK;

  rominit_seq dut (
    .CLK(CLK), .RES(RES), .DL_ACTIVE(DL_ACTIVE), .DL_INDEX(DL_INDEX),
    .DL_DATA(DL_DATA), .DL_WR(DL_WR),
    .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT), .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR),
    .ROMINIT_SEL_APU(ROMINIT_SEL_APU), .ROMINIT_SEL_CART(ROMINIT_SEL_CART),
    .ROMINIT_ADDR(ROMINIT_ADDR), .ROMINIT_DATA(ROMINIT_DATA),
    .ROMINIT_VALID(ROMINIT_VALID), .CART_SIZE(CART_SIZE), .READY(READY),
    .SYS_RESB(SYS_RESB), .ERR(ERR)
  );

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [3:0]  sel;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          vcount = 0;
  logic [24:0] last_addr = '0;
  int          cur_cnt, cur_lim, v0;
  logic [3:0]  cur_sel;
  logic        resb_in_load;

  wire [3:0] sels = {ROMINIT_SEL_CART, ROMINIT_SEL_APU, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (ROMINIT_VALID === 1'b1) begin
      vcount++;
      last_addr = ROMINIT_ADDR;
      chk("valid_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("rom_addr", 32'(ROMINIT_ADDR), 32'(mon_e.addr));
        chk("rom_data", 32'(ROMINIT_DATA), 32'(mon_e.data));
        chk("rom_sel", 32'(sels), 32'(mon_e.sel));
      end
    end
  end

  task automatic start_dl(input logic [7:0] idx, input logic [3:0] esel, input int lim);
    @(posedge CLK); #1;
    DL_INDEX  = idx;
    DL_ACTIVE = 1'b1;
    @(posedge CLK); #1;
    chk("sel_on_entry", 32'(sels), 32'(esel));
    resb_in_load = SYS_RESB;
    cur_sel = esel;
    cur_lim = lim;
    cur_cnt = 0;
  endtask

  task automatic send_byte(input bit fall);
    exp_t       e;
    logic [7:0] d;
    d        = 8'($urandom);
    DL_WR    = 1'b1;
    DL_DATA  = d;
    DL_INDEX = 8'($urandom);
    if (fall) DL_ACTIVE = 1'b0;
    if (cur_cnt < cur_lim) begin
      e.addr = 25'(cur_cnt);
      e.data = d;
      e.sel  = cur_sel;
      sb_q.push_back(e);
      cur_cnt++;
    end
    @(posedge CLK); #1;
    DL_WR = 1'b0;
  endtask

  // Returns one cycle after CHECK (or after SKIP exits), with state back in IDLE.
  task automatic run_dl(input logic [7:0] idx, input logic [3:0] esel, input int lim,
                        input int nbytes, input int gap, input bit conc);
    start_dl(idx, esel, lim);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(conc && (i == nbytes - 1));
      repeat (gap - 1) begin @(posedge CLK); #1; end
    end
    if (!conc) begin
      DL_ACTIVE = 1'b0;
      @(posedge CLK); #1;
    end
    chk("sel_in_check", 32'(sels), 32'(esel));
    @(posedge CLK); #1;
    chk("sel_after_check", 32'(sels), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_hold_release();
    repeat (63) begin @(posedge CLK); #1; end
    chk("resb_before_hold_end", 32'(SYS_RESB), 32'd0);
    @(posedge CLK); #1;
    chk("resb_at_hold_end", 32'(SYS_RESB), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_sel", 32'(sels), 32'd0);
    chk("rst_valid", 32'(ROMINIT_VALID), 32'd0);
    chk("rst_addr", 32'(ROMINIT_ADDR), 32'd0);
    chk("rst_data", 32'(ROMINIT_DATA), 32'd0);
    chk("rst_cart_size", 32'(CART_SIZE), 32'd0);
    chk("rst_ready", 32'(READY), 32'd0);
    chk("rst_resb", 32'(SYS_RESB), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    RES = 1'b0;

    run_dl(8'd0, 4'b0001, 4096, 4096, 1, 1'b0);
    chk("boot_last_addr", 32'(last_addr), 32'd4095);
    chk("ready_after_boot", 32'(READY), 32'd0);
    run_dl(8'd1, 4'b0010, 1024, 1024, 1, 1'b1);
    chk("chr_last_addr", 32'(last_addr), 32'd1023);
    run_dl(8'd2, 4'b0100, 2048, 2048, 1, 1'b0);
    chk("apu_last_addr", 32'(last_addr), 32'd2047);
    chk("ready_after_three", 32'(READY), 32'd1);
    chk("err_after_three", 32'(ERR), 32'd0);
    chk("resb_right_after_check", 32'(SYS_RESB), 32'd0);
    check_hold_release();

    run_dl(8'd3, 4'b1000, 131072, 8192, 3, 1'b0);
    chk("cart_resb_low_in_load", 32'(resb_in_load), 32'd0);
    chk("cart_size", 32'(CART_SIZE), 32'd8192);
    chk("cart_err", 32'(ERR), 32'd0);
    check_hold_release();

    run_dl(8'd1, 4'b0010, 1024, 1023, 1, 1'b0);
    chk("short_chr_err", 32'(ERR), 32'd1);
    chk("short_chr_ready", 32'(READY), 32'd0);
    repeat (70) begin @(posedge CLK); #1; end
    chk("short_chr_resb", 32'(SYS_RESB), 32'd0);

    v0 = vcount;
    run_dl(8'd2, 4'b0100, 2048, 2050, 1, 1'b0);
    chk("long_apu_pulses", 32'(vcount - v0), 32'd2048);
    chk("long_apu_last_addr", 32'(last_addr), 32'd2047);
    chk("long_apu_err", 32'(ERR), 32'd1);
    run_dl(8'd1, 4'b0010, 1024, 1024, 1, 1'b0);
    chk("apu_flag_clear_ready", 32'(READY), 32'd0);

    v0 = vcount;
    run_dl(8'd7, 4'b0000, 0, 100, 1, 1'b0);
    chk("skip_no_valid", 32'(vcount - v0), 32'd0);
    chk("skip_err_kept", 32'(ERR), 32'd1);
    chk("skip_cart_kept", 32'(CART_SIZE), 32'd8192);
    chk("skip_ready_kept", 32'(READY), 32'd0);

    start_dl(8'd0, 4'b0001, 4096);
    for (int i = 0; i < 2000; i++) send_byte(1'b0);
    RES       = 1'b1;
    DL_ACTIVE = 1'b0;
    @(posedge CLK); #1;
    chk("res_mid_sel", 32'(sels), 32'd0);
    chk("res_mid_ready", 32'(READY), 32'd0);
    chk("res_mid_err", 32'(ERR), 32'd0);
    chk("res_mid_valid", 32'(ROMINIT_VALID), 32'd0);
    chk("res_mid_cart", 32'(CART_SIZE), 32'd0);
    chk("res_mid_sb", 32'(sb_q.size()), 32'd0);
    repeat (2) begin @(posedge CLK); #1; end
    RES = 1'b0;
    run_dl(8'd0, 4'b0001, 4096, 4096, 1, 1'b0);
    chk("reload_boot_err", 32'(ERR), 32'd0);
    run_dl(8'd1, 4'b0010, 1024, 1024, 1, 1'b0);
    run_dl(8'd2, 4'b0100, 2048, 2048, 1, 1'b0);
    chk("boot_flag_after_res", 32'(READY), 32'd1);
    check_hold_release();

    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
